// File: rtl/md4_arbiter.sv
// md4_arbiter: round-robin sharing of one md4block core among NREQ requesters.
// Define MD4ARB_TIMEOUT_EN to add the WAIT-state watchdog (limit = TIMEOUT).
`timescale 1ns/1ps
module md4_arbiter #(
  parameter int          NREQ    = 4,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*128-1:0]  req_state,
  input  logic [NREQ*512-1:0]  req_data,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      resp_valid,
  output logic [127:0]         resp_state,
  output logic                 resp_err,
  input  logic [NREQ-1:0]      resp_ack,
  output logic                 md4_irdy,
  output logic [31:0]          md4_state_a,
  output logic [31:0]          md4_state_b,
  output logic [31:0]          md4_state_c,
  output logic [31:0]          md4_state_d,
  output logic [511:0]         md4_data,
  input  logic                 md4_ordy,
  input  logic [127:0]         md4_newstate
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FIRE1, S_FIRE2, S_DROP, S_WAIT, S_RESP
  } state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_ptr, r_idx, w_sel, w_ptr_nxt;
  logic [NREQ-1:0] r_grant, r_rvalid, w_onehot;
  logic [127:0]    r_st, r_resp;
  logic [511:0]    r_data;
  logic            r_irdy;
  logic            w_found, w_ack, w_timeout;
  int              w_j;

  // Lowest rotated offset from r_ptr wins, so scan offsets high to low.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_j     = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_j = (int'(r_ptr) + i) % NREQ;
      if (req_valid[w_j]) begin
        w_found = 1'b1;
        w_sel   = IW'(w_j);
      end
    end
  end

  assign w_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
  assign w_ack     = resp_ack[r_idx];
  assign w_ptr_nxt = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;

`ifdef MD4ARB_TIMEOUT_EN
  logic [15:0] r_wd;
  logic        r_err;

  assign w_timeout = (r_wd == TIMEOUT - 16'd1);
  assign resp_err  = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_DROP)
        r_wd <= '0;
      else if (r_state == S_WAIT && !md4_ordy && !w_timeout)
        r_wd <= r_wd + 16'd1;
      if (r_state == S_WAIT && !md4_ordy && w_timeout)
        r_err <= 1'b1;
      else if (r_state == S_RESP && w_ack)
        r_err <= 1'b0;
    end
  end
`else
  logic w_unused;
  assign w_unused  = ^TIMEOUT;
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_found) w_next = S_LOAD;
      S_LOAD:  w_next = S_FIRE1;
      S_FIRE1: w_next = S_FIRE2;
      S_FIRE2: w_next = S_DROP;
      S_DROP:  w_next = S_WAIT;
      S_WAIT:  if (md4_ordy || w_timeout) w_next = S_RESP;
      S_RESP:  if (w_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_idx    <= '0;
      r_grant  <= '0;
      r_rvalid <= '0;
      r_resp   <= '0;
      r_st     <= '0;
      r_data   <= '0;
      r_irdy   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_found) begin
          r_idx   <= w_sel;
          r_grant <= w_onehot;
        end
        S_LOAD: begin
          r_st   <= req_state[int'(r_idx)*128 +: 128];
          r_data <= req_data[int'(r_idx)*512 +: 512];
        end
        S_FIRE1, S_FIRE2: r_irdy <= 1'b1;
        S_DROP:  r_irdy <= 1'b0;
        S_WAIT: if (md4_ordy) begin
          r_resp   <= md4_newstate;
          r_rvalid <= r_grant;
        end else if (w_timeout) begin
          r_resp   <= '0;
          r_rvalid <= r_grant;
        end
        S_RESP: if (w_ack) begin
          r_rvalid <= '0;
          r_grant  <= '0;
          r_ptr    <= w_ptr_nxt;
        end
        default: ;
      endcase
    end
  end

  assign grant       = r_grant;
  assign resp_valid  = r_rvalid;
  assign resp_state  = r_resp;
  assign md4_irdy    = r_irdy;
  assign md4_state_a = r_st[127:96];
  assign md4_state_b = r_st[95:64];
  assign md4_state_c = r_st[63:32];
  assign md4_state_d = r_st[31:0];
  assign md4_data    = r_data;
endmodule

// File: doc/md4_arbiter.md
MD4_ARBITER -- requirements
Module: md4_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 16'd1000, giving the watchdog limit in cycles; it is used only with MD4ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, NREQ bits: requester i has a block pending.
REQ-006 SHALL have port req_state, input, NREQ*128 bits: per-requester chaining state, packed {a,b,c,d}, slice i at [128*i +: 128].
REQ-007 SHALL have port req_data, input, NREQ*512 bits: per-requester 512-bit message block, slice i at [512*i +: 512].
REQ-008 SHALL have port grant, output, NREQ bits: one-hot, marking the requester being served.
REQ-009 SHALL have port resp_valid, output, NREQ bits: one-hot, marking that the result for requester i is ready.
REQ-010 SHALL have port resp_state, output, 128 bits: result {a,b,c,d}, shared by all requesters.
REQ-011 SHALL have port resp_err, output, 1 bit: the result was aborted by the watchdog.
REQ-012 SHALL have port resp_ack, input, NREQ bits: requester i consumes its result.
REQ-013 SHALL have ports md4_irdy (output, 1), md4_state_a/b/c/d (output, 32 each), md4_data (output, 512), md4_ordy (input, 1) and md4_newstate (input, 128, {a,b,c,d}), all connecting to md4block.

Function
REQ-014 SHALL implement the states IDLE, LOAD, FIRE1, FIRE2, DROP, WAIT, RESP.
REQ-015 In IDLE, if any req_valid is set, SHALL select the first set bit searching from rr_ptr upward with wrap-around, register the index, set that grant bit, and go to LOAD.
REQ-016 In LOAD, SHALL register req_state and req_data of the granted index onto md4_state_* and md4_data, then go to FIRE1; a requester may drop req_valid after this cycle without effect.
REQ-017 In FIRE1, SHALL set md4_irdy=1; FIRE2 SHALL hold it; DROP SHALL clear it and go to WAIT. md4_irdy is therefore high for exactly 2 cycles.
REQ-018 In WAIT, on md4_ordy=1, SHALL latch md4_newstate into resp_state, set resp_valid[grant]=1, and go to RESP.
REQ-019 In RESP, on resp_ack[granted index]=1, SHALL clear resp_valid and grant, set rr_ptr to (index+1) mod NREQ, and return to IDLE.
REQ-020 resp_ack bits for any other index, or any resp_ack outside RESP, SHALL be ignored.
REQ-021 md4_state_* and md4_data SHALL remain stable from LOAD until RESP exits.
REQ-022 resp_state SHALL remain stable while resp_valid is set.
REQ-023 Latency SHALL be: req_valid seen at edge k gives grant at k+1, md4_irdy high at k+3..k+4, and resp_valid one cycle after the first md4_ordy seen in WAIT.
REQ-024 A requester asserting req_valid in the same cycle as its resp_ack SHALL be served only after every other pending requester, because rr_ptr has already advanced past it.
REQ-025 If all requesters are continuously valid, service SHALL follow 0,1,…,NREQ-1,0, with no starvation.
REQ-026 grant and resp_valid SHALL each be one-hot or zero at all times.
REQ-027 Only one block SHALL be in flight; no new request is accepted before RESP exits.

Reset
REQ-028 On rst=1 at any state, the block SHALL enter IDLE and drive grant=0, resp_valid=0, resp_state=0, resp_err=0, md4_irdy=0, md4_state_*=0, md4_data=0, rr_ptr=0, watchdog=0.
REQ-029 Reset during WAIT SHALL discard the in-flight result; a late md4_ordy after reset SHALL be ignored in IDLE.

Configuration
REQ-030 With macro MD4ARB_TIMEOUT_EN defined, SHALL implement a 16-bit watchdog that clears on entry to WAIT and increments each WAIT cycle.
REQ-031 With MD4ARB_TIMEOUT_EN defined, if the watchdog reaches TIMEOUT before md4_ordy, SHALL set resp_err=1, set resp_state=0, set resp_valid[grant], and enter RESP; resp_err SHALL clear when RESP exits.
REQ-032 Without MD4ARB_TIMEOUT_EN, SHALL implement no watchdog logic, tie resp_err to 0, and wait in WAIT indefinitely.

Verification
REQ-033 Single request: req_valid=4'b0001 with the MD4 initial state and the padded empty-message block, using real md4block -> grant=0001, 2-cycle md4_irdy, resp_state byte-swapped equals 31d6cfe0d16ae931b73c59d7e0c089c0, resp_valid=0001 until resp_ack=0001.
REQ-034 Round-robin: req_valid=4'b1111 held, each result acked immediately -> grant sequence 0001,0010,0100,1000,0001.
REQ-035 Re-request on ack: req_valid=4'b0011 held, requester 0 acked -> next grant=0010, not 0001.
REQ-036 Wrong ack: resp_valid=0100 with resp_ack=0001 applied for 5 cycles -> state stays RESP and resp_valid stays 0100.
REQ-037 Reset mid-operation: rst pulsed 1 cycle during WAIT, then md4_ordy=1 -> all outputs 0, no resp_valid, next grant starts from index 0.
REQ-038 Timeout (with MD4ARB_TIMEOUT_EN, TIMEOUT=20, core ordy stuck at 0) -> resp_valid set and resp_err=1 exactly 20 WAIT cycles after entering WAIT, resp_state=0; without the macro -> resp_err stays 0 and the block stays in WAIT.
